// File: rtl/csr_access_unit.sv
// CSR instruction sequencer: decodes CSRRW/RS/RC (register and immediate forms),
// performs the read-modify-write against the machine CSR block and returns the old value.
module csr_access_unit #(
  parameter int DATA_W     = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_rs1_data,
  input  logic [4:0]            req_zimm,
  input  logic                  req_rs1_zero,
  input  logic                  req_rd_zero,
  input  logic                  flush,
  output logic                  csr_rd,
  output logic                  csr_wr,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0]     csr_wdata,
  input  logic [DATA_W-1:0]     csr_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rd_data,
  output logic                  resp_rd_we,
  output logic                  resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [CSR_ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]       opnd_q, old_q;
  logic                    opzero_q, rd_zero_q, illegal_q;

  logic [DATA_W-1:0]       req_opnd;
  logic                    req_opzero, req_is_rw, req_need_read, req_need_write, req_illegal;
  logic                    accept, is_rw_q, need_read_q, need_write_q;

  always_comb begin
    req_opnd       = req_funct3[2] ? {{(DATA_W-5){1'b0}}, req_zimm} : req_rs1_data;
    req_opzero     = req_funct3[2] ? (req_zimm == 5'd0) : req_rs1_zero;
    req_is_rw      = (req_funct3[1:0] == 2'b01);
    req_need_read  = !(req_is_rw && req_rd_zero);
    req_need_write = req_is_rw || !req_opzero;
    // Top two address bits == 2'b11 marks a read-only CSR
    req_illegal    = (req_funct3[1:0] == 2'b00) ||
                     (req_need_write && (req_addr[CSR_ADDR_W-1 -: 2] == 2'b11));
    accept         = (state == IDLE) && req_valid && !flush;
    is_rw_q        = (op_q == 2'b01);
    need_read_q    = !(is_rw_q && rd_zero_q);
    need_write_q   = is_rw_q || !opzero_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      opnd_q    <= '0;
      old_q     <= '0;
      opzero_q  <= 1'b0;
      rd_zero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= req_funct3[1:0];
        addr_q    <= req_addr;
        opnd_q    <= req_opnd;
        opzero_q  <= req_opzero;
        rd_zero_q <= req_rd_zero;
        illegal_q <= req_illegal;
        old_q     <= '0;
      end else if (state == READ) begin
        old_q <= csr_rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    csr_rd       = 1'b0;
    csr_wr       = 1'b0;
    csr_addr     = '0;
    csr_wdata    = '0;
    resp_valid   = 1'b0;
    resp_rd_data = '0;
    resp_rd_we   = 1'b0;
    resp_illegal = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_illegal)        state_nxt = RESP;
          else if (req_need_read) state_nxt = READ;
          else                    state_nxt = WRITE;
        end
      end
      READ: begin
        csr_rd   = 1'b1;
        csr_addr = addr_q;
        if (flush)             state_nxt = IDLE;
        else if (need_write_q) state_nxt = WRITE;
        else                   state_nxt = RESP;
      end
      WRITE: begin
        csr_wr   = 1'b1;
        csr_addr = addr_q;
        case (op_q)
          2'b01:   csr_wdata = opnd_q;
          2'b10:   csr_wdata = old_q | opnd_q;
          2'b11:   csr_wdata = old_q & ~opnd_q;
          default: csr_wdata = '0;
        endcase
        // A flush here still lets the write land but drops the response
        state_nxt = flush ? IDLE : RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rd_data = old_q;
        resp_rd_we   = need_read_q && !rd_zero_q && !illegal_q;
        resp_illegal = illegal_q;
        if (flush || resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: sequencing, latency, write data, flush and reset cases.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_rs1_data = '0;
  logic [4:0]  req_zimm = '0;
  logic        req_rs1_zero = 1'b0;
  logic        req_rd_zero = 1'b0;
  logic        flush = 1'b0;
  logic        csr_rd, csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rd_data;
  logic        resp_rd_we, resp_illegal;

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_wdata = '0;
  int          lat;

  csr_access_unit #(.DATA_W(32), .CSR_ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_zimm(req_zimm),
    .req_rs1_zero(req_rs1_zero), .req_rd_zero(req_rd_zero), .flush(flush),
    .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_data(resp_rd_data), .resp_rd_we(resp_rd_we), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csr_rd) rd_cnt++;
    if (csr_wr) begin
      wr_cnt++;
      last_wdata = csr_wdata;
    end
    if (csr_rd && csr_wr) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    last_wdata = '0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] z, input logic rs1z, input logic rdz);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = a;
    req_rs1_data = rs1;
    req_zimm     = z;
    req_rs1_zero = rs1z;
    req_rd_zero  = rdz;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int l);
    l = 1;
    while (!resp_valid && l < 8) begin
      tick();
      l++;
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] rs1, input logic [4:0] z, input logic rs1z,
                         input logic rdz, input int exp_lat, input int exp_rd, input int exp_wr,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_we, input logic exp_ill);
    int l;
    clear_counts();
    issue(f3, a, rs1, z, rs1z, rdz);
    wait_resp(l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_rdcnt"}, rd_cnt, exp_rd);
    check({tag, "_wrcnt"}, wr_cnt, exp_wr);
    if (exp_wr > 0) check({tag, "_wdata"}, last_wdata, exp_wdata);
    check({tag, "_rddata"}, resp_rd_data, exp_rdata);
    check({tag, "_we"}, resp_rd_we, exp_we);
    check({tag, "_ill"}, resp_illegal, exp_ill);
    tick();
    check({tag, "_done"}, resp_valid, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rd", csr_rd, 1'b0);
    check("rst_wr", csr_wr, 1'b0);
    check("rst_resp", resp_valid, 1'b0);
    check("rst_rddata", resp_rd_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // CSRRS step by step
    csr_rdata = 32'h1800;
    clear_counts();
    check("rs_ready", req_ready, 1'b1);
    issue(3'b010, 12'h300, 32'h8, 5'd0, 1'b0, 1'b0);
    check("rs_c1_rd", csr_rd, 1'b1);
    check("rs_c1_wr", csr_wr, 1'b0);
    check("rs_c1_addr", csr_addr, 12'h300);
    tick();
    check("rs_c2_wr", csr_wr, 1'b1);
    check("rs_c2_rd", csr_rd, 1'b0);
    check("rs_c2_wdata", csr_wdata, 32'h1808);
    check("rs_c2_addr", csr_addr, 12'h300);
    tick();
    check("rs_c3_valid", resp_valid, 1'b1);
    check("rs_c3_data", resp_rd_data, 32'h1800);
    check("rs_c3_we", resp_rd_we, 1'b1);
    check("rs_c3_ill", resp_illegal, 1'b0);
    check("rs_c3_ready", req_ready, 1'b0);
    tick();
    check("rs_idle_valid", resp_valid, 1'b0);
    check("rs_idle_ready", req_ready, 1'b1);
    check("rs_idle_addr", csr_addr, 12'h0);

    csr_rdata = 32'hDEAD_BEEF;
    run_req("rw_rdz", 3'b001, 12'h341, 32'h8000_0004, 5'd0, 1'b0, 1'b1, 2, 0, 1, 32'h8000_0004, 32'h0, 1'b0, 1'b0);
    csr_rdata = 32'h0;
    run_req("rci_z0", 3'b111, 12'hF14, 32'hFFFF, 5'd0, 1'b0, 1'b0, 2, 1, 0, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("rwi_ro", 3'b101, 12'hF11, 32'h0, 5'd5, 1'b0, 1'b0, 1, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1);
    run_req("f3_100", 3'b100, 12'hF11, 32'h0, 5'd5, 1'b0, 1'b0, 1, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1);
    csr_rdata = 32'hFF;
    run_req("rc", 3'b011, 12'h340, 32'h0F, 5'd0, 1'b0, 1'b0, 3, 1, 1, 32'hF0, 32'hFF, 1'b1, 1'b0);
    csr_rdata = 32'h100;
    run_req("rsi", 3'b110, 12'h305, 32'h0, 5'h1F, 1'b0, 1'b0, 3, 1, 1, 32'h11F, 32'h100, 1'b1, 1'b0);
    csr_rdata = 32'h1234;
    run_req("rs_ro_x0", 3'b010, 12'hC00, 32'hFFFF, 5'd0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h1234, 1'b1, 1'b0);
    run_req("rs_ro_wr", 3'b010, 12'hC00, 32'h1, 5'd0, 1'b0, 1'b0, 1, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1);

    // flush in the accept cycle
    clear_counts();
    flush = 1'b1;
    issue(3'b010, 12'h300, 32'h8, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    check("fl_acc_ready", req_ready, 1'b1);
    tick();
    tick();
    check("fl_acc_rdcnt", rd_cnt, 0);
    check("fl_acc_valid", resp_valid, 1'b0);

    // flush during READ
    clear_counts();
    issue(3'b010, 12'h300, 32'h8, 5'd0, 1'b0, 1'b0);
    check("fl_rd_inread", csr_rd, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rd_ready", req_ready, 1'b1);
    tick();
    tick();
    check("fl_rd_wrcnt", wr_cnt, 0);
    check("fl_rd_valid", resp_valid, 1'b0);

    // flush during WRITE
    clear_counts();
    issue(3'b001, 12'h341, 32'h77, 5'd0, 1'b0, 1'b1);
    check("fl_wr_inwrite", csr_wr, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_wr_wrcnt", wr_cnt, 1);
    check("fl_wr_valid", resp_valid, 1'b0);
    check("fl_wr_ready", req_ready, 1'b1);

    // response held while resp_ready is low
    resp_ready = 1'b0;
    csr_rdata  = 32'h55;
    clear_counts();
    issue(3'b010, 12'h300, 32'hA0, 5'd0, 1'b0, 1'b0);
    wait_resp(lat);
    check("stall_lat", lat, 3);
    check("stall_wdata", last_wdata, 32'hF5);
    csr_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", resp_valid, 1'b1);
      check("stall_data", resp_rd_data, 32'h55);
      check("stall_we", resp_rd_we, 1'b1);
    end
    resp_ready = 1'b1;
    tick();
    check("stall_release", resp_valid, 1'b0);

    // flush while holding a response
    resp_ready = 1'b0;
    issue(3'b001, 12'h341, 32'h1, 5'd0, 1'b0, 1'b1);
    wait_resp(lat);
    check("fl_resp_lat", lat, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    resp_ready = 1'b1;
    check("fl_resp_valid", resp_valid, 1'b0);
    check("fl_resp_ready", req_ready, 1'b1);

    // asynchronous reset in the middle of WRITE
    clear_counts();
    issue(3'b001, 12'h341, 32'hABCD, 5'd0, 1'b0, 1'b1);
    check("rstw_inwrite", csr_wr, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("rstw_wr", csr_wr, 1'b0);
    check("rstw_addr", csr_addr, 12'h0);
    check("rstw_wdata", csr_wdata, 32'h0);
    check("rstw_ready", req_ready, 1'b1);
    check("rstw_valid", resp_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    tick();
    check("rstw_wrcnt", wr_cnt, 0);
    check("rstw_after", resp_valid, 1'b0);
    check("no_rd_wr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path width of CSR values and operands.
REQ-002 Parameter CSR_ADDR_W, default 12, CSR address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  pipeline presents a CSR instruction.
REQ-006 req_ready  output  1  unit can accept a request (IDLE only).
REQ-007 req_funct3  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; other codes illegal.
REQ-008 req_addr  input  CSR_ADDR_W  target CSR address.
REQ-009 req_rs1_data  input  DATA_W  rs1 operand (register forms).
REQ-010 req_zimm  input  5  immediate operand (I forms), zero-extended to DATA_W.
REQ-011 req_rs1_zero  input  1  rs1 index is x0 (register forms); ignored for I forms.
REQ-012 req_rd_zero  input  1  destination index is x0.
REQ-013 flush  input  1  pipeline flush request.
REQ-014 csr_rd  output  1  read strobe to machine CSR block.
REQ-015 csr_wr  output  1  write strobe to machine CSR block.
REQ-016 csr_addr  output  CSR_ADDR_W  CSR address to machine CSR block.
REQ-017 csr_wdata  output  DATA_W  write data to machine CSR block.
REQ-018 csr_rdata  input  DATA_W  read data from machine CSR block, valid combinationally in the cycle csr_rd=1.
REQ-019 resp_valid  output  1  result available.
REQ-020 resp_ready  input  1  pipeline accepts result.
REQ-021 resp_rd_data  output  DATA_W  old CSR value for rd write-back.
REQ-022 resp_rd_we  output  1  rd write-back enable.
REQ-023 resp_illegal  output  1  illegal-instruction indication for this request.

Function
REQ-024 FSM states IDLE, READ, WRITE, RESP; one-hot or binary encoding is free.
REQ-025 IDLE: req_ready=1; on req_valid latch funct3, addr, operand (zimm for funct3[2]=1, else rs1_data), rs1_zero/rd_zero flags.
REQ-026 Operand-zero flag for I forms = (zimm==0); for register forms = req_rs1_zero.
REQ-027 need_read = !(RW/RWI with rd_zero); need_write = RW/RWI, or RS/RC/RSI/RCI with operand-zero flag clear.
REQ-028 Illegal when funct3 not in listed set, or need_write and addr[11:10]==2'b11 (read-only); illegal request goes IDLE->RESP with resp_illegal=1, resp_rd_we=0, no csr_rd/csr_wr pulse.
REQ-029 Legal: IDLE->READ if need_read, else IDLE->WRITE; READ->WRITE if need_write, else READ->RESP; WRITE->RESP.
REQ-030 READ: csr_rd=1 exactly one cycle; csr_rdata captured into old-value register at end of cycle.
REQ-031 WRITE: csr_wr=1 exactly one cycle; csr_wdata = operand (RW), old|operand (RS), old&~operand (RC); old=0 when read skipped.
REQ-032 csr_addr = latched address in READ and WRITE, 0 elsewhere; csr_wdata 0 outside WRITE.
REQ-033 RESP: resp_valid=1, resp_rd_data=old value, resp_rd_we = need_read & !rd_zero & !illegal; outputs stable until resp_ready; RESP->IDLE on resp_ready.
REQ-034 Latency request-accept to resp_valid: 3 cycles read+write, 2 cycles read-only or write-only, 1 cycle illegal.
REQ-035 flush in READ or IDLE-accept cycle: abandon request, no csr_wr, return to IDLE next cycle, no resp_valid.
REQ-036 flush in WRITE: write still completes; request dropped, return to IDLE, no resp_valid.
REQ-037 flush in RESP: resp_valid deasserts next cycle, return to IDLE.
REQ-038 csr_rd and csr_wr never asserted in the same cycle.

Reset
REQ-039 rst low: state IDLE immediately; req_ready=1, csr_rd=0, csr_wr=0, csr_addr=0, csr_wdata=0, resp_valid=0, resp_rd_data=0, resp_rd_we=0, resp_illegal=0; latched fields and old-value register cleared.
REQ-040 Reset mid-operation aborts with no further CSR strobe after release.

Verification
REQ-041 CSRRS addr 0x300, rs1_data 0x8, csr_rdata 0x1800, resp_ready=1 -> csr_rd cycle 1, csr_wr cycle 2 wdata 0x1808, resp_valid cycle 3 rd_data 0x1800 rd_we=1.
REQ-042 CSRRW rd_zero=1 addr 0x341 rs1_data 0x80000004 -> no csr_rd, csr_wr wdata 0x80000004, resp_rd_we=0.
REQ-043 CSRRCI zimm=0 addr 0xF14, csr_rdata 0x0 -> read only, no csr_wr, no illegal, rd_data 0x0.
REQ-044 CSRRWI addr 0xF11 -> resp_illegal=1 one cycle after accept, no strobes; funct3=100 same result.
REQ-045 flush asserted during READ of CSRRS -> no csr_wr, no resp_valid, req_ready=1 next cycle.
REQ-046 resp_ready held low 4 cycles in RESP -> resp fields stable; rst low mid-WRITE -> all outputs zero asynchronously.
